// File: rtl/shift_rotate_iter_if.sv
// Operand/result bundle between the control unit and the iterative shift/rotate unit.
// The control unit drives the master side; the execution unit is the slave.
interface shift_rotate_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] A;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (output start, op, B, A, input busy, done, result);
    modport slave  (input start, op, B, A, output busy, done, result);
endinterface

// File: rtl/shift_rotate_iter.sv
// Iterative shift/rotate unit: shifts STEP bits per cycle with a start/busy/done handshake.
// Optional build macro SHIFT_AMT_SAT_EN: logical/arithmetic shifts by A >= WIDTH saturate in one cycle.
module shift_rotate_iter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                 clock,
    input  logic                 clear,
    shift_rotate_iter_if.slave   bus
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_SHR  = 3'd0;
    localparam logic [2:0] OP_SHRA = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_ROR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;

    localparam logic [SW:0] STEP_C  = (SW+1)'(STEP);
    localparam logic [SW:0] WIDTH_C = (SW+1)'(WIDTH);

    logic [1:0]       state_q,  state_d;
    logic [2:0]       op_q,     op_d;
    logic [WIDTH-1:0] work_q,   work_d;
    logic [SW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [SW-1:0]    n_amt;
    logic             is_pass;
    logic [SW:0]      step_amt;

    // One partial step; s never exceeds STEP, so s is always below WIDTH.
    function automatic logic [WIDTH-1:0] step_shift(
        input logic [WIDTH-1:0] v,
        input logic [2:0]       o,
        input logic [SW:0]      s
    );
        logic [WIDTH-1:0] r;
        case (o)
            OP_SHR:  r = v >> s;
            OP_SHRA: r = $unsigned($signed(v) >>> s);
            OP_SHL:  r = v << s;
            OP_ROR:  r = (v >> s) | (v << (WIDTH_C - s));
            OP_ROL:  r = (v << s) | (v >> (WIDTH_C - s));
            default: r = v;
        endcase
        return r;
    endfunction

    assign n_amt   = bus.A[SW-1:0];
    assign is_pass = (bus.op > OP_ROL);

`ifdef SHIFT_AMT_SAT_EN
    localparam logic [WIDTH-1:0] WIDTH_A = (WIDTH)'(WIDTH);
    logic             sat_hit;
    logic [WIDTH-1:0] sat_val;
    assign sat_hit = (bus.op <= OP_SHL) && (bus.A >= WIDTH_A);
    assign sat_val = (bus.op == OP_SHRA) ? {WIDTH{bus.B[WIDTH-1]}} : '0;
`else
    logic unused_a_hi;
    assign unused_a_hi = ^bus.A[WIDTH-1:SW];
`endif

    assign step_amt = ({1'b0, cnt_q} < STEP_C) ? {1'b0, cnt_q} : STEP_C;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d   = bus.op;
                    work_d = bus.B;
                    cnt_d  = n_amt;
                    state_d = S_RUN;
`ifdef SHIFT_AMT_SAT_EN
                    // Saturation must win over N==0 (e.g. A=32 is a full shift-out).
                    if (sat_hit) begin
                        result_d = sat_val;
                        cnt_d    = '0;
                        state_d  = S_DONE;
                    end else
`endif
                    if (is_pass || (n_amt == '0)) begin
                        result_d = bus.B;
                        cnt_d    = '0;
                        state_d  = S_DONE;
                    end
                end
            end
            S_RUN: begin
                work_d = step_shift(work_q, op_q, step_amt);
                cnt_d  = cnt_q - step_amt[SW-1:0];
                // Result is loaded on the last step so it is valid while done is high.
                if (cnt_d == '0) begin
                    result_d = work_d;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;

endmodule
